// File: rtl/sweep_pkg.sv
// Shared types and helpers for truth_table_sweeper and sweep_vec_gen.
// The gray() helper is used only when SWEEP_GRAY_EN is defined.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

  localparam int unsigned N_IN_DEFAULT    = 3;
  localparam int unsigned TABLE_W_DEFAULT = 32'd1 << N_IN_DEFAULT;
  localparam int unsigned GRAY_W          = 16;

  function automatic int unsigned table_w(input int unsigned n);
    return 32'd1 << n;
  endfunction

  function automatic logic [GRAY_W-1:0] gray(input logic [GRAY_W-1:0] v);
    return v ^ (v >> 1);
  endfunction

endpackage

// File: rtl/sweep_vec_gen.sv
// Step register and settle down-counter for the sweep. Produces the DUT input
// vector, a sample strobe and a last-step flag. Gray ordering when SWEEP_GRAY_EN is defined.
module sweep_vec_gen
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_run,
  output logic [N_IN-1:0] o_vec,
  output logic            o_sample,
  output logic            o_last
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  logic [N_IN-1:0] r_step;
  logic [3:0]      r_cnt;
  logic            w_tc;

  assign w_tc     = (r_cnt == 4'd0);
  assign o_sample = i_run && w_tc;
  assign o_last   = (r_step == {N_IN{1'b1}});

  // The step holds on the last vector so dut_in stays put through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_step <= '0;
      r_cnt  <= SETTLE_L;
    end else if (i_run) begin
      if (w_tc) begin
        r_cnt <= SETTLE_L;
        if (!o_last) begin
          r_step <= r_step + 1'b1;
        end
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

`ifdef SWEEP_GRAY_EN
  logic [GRAY_W-1:0] w_gray;
  assign w_gray = gray(GRAY_W'(r_step));
  assign o_vec  = w_gray[N_IN-1:0];
`else
  assign o_vec = r_step;
`endif

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all input combinations of an N_IN-input combinational DUT and captures its truth table.
// Compares the table against an expected one; SWEEP_GRAY_EN selects Gray drive order.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  input  logic [2**N_IN-1:0]   expected,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_cnt
);

  localparam int unsigned TABLE_W = table_w(N_IN);

  sweep_state_e       r_state;
  sweep_state_e       w_state_nxt;
  logic               w_load;
  logic               w_run;
  logic               w_sample;
  logic               w_last;
  logic               w_bit_err;
  logic [TABLE_W-1:0] r_table;
  logic [TABLE_W-1:0] w_table_nxt;
  logic [N_IN:0]      r_mcnt;
  logic               r_pass;

  assign w_load = (r_state == IDLE) && start;
  assign w_run  = (r_state == DRIVE);

  sweep_vec_gen #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_vec_gen (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_run    (w_run),
    .o_vec    (dut_in),
    .o_sample (w_sample),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        busy = 1'b1;
        if (w_sample && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Table indexed by the driven value, so Gray and binary order fill it identically.
  always_comb begin
    w_table_nxt          = r_table;
    w_table_nxt[dut_in]  = dut_out;
  end

  assign w_bit_err = dut_out ^ expected[dut_in];

  // pass compares the table including the bit being written on the final sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_table <= '0;
      r_mcnt  <= '0;
      r_pass  <= 1'b0;
    end else if (w_load) begin
      r_table <= '0;
      r_mcnt  <= '0;
      r_pass  <= 1'b0;
    end else if (w_sample) begin
      r_table <= w_table_nxt;
      r_mcnt  <= r_mcnt + {{N_IN{1'b0}}, w_bit_err};
      if (w_last) begin
        r_pass <= (w_table_nxt == expected);
      end
    end
  end

  assign table_out    = r_table;
  assign mismatch_cnt = r_mcnt;
  assign pass         = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one SETTLE=2 instance and one SETTLE=0 instance.
// Expected dut_in order follows SWEEP_GRAY_EN when the bench is built with it.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst;
  logic       start0, start1;
  logic [2:0] din0, din1;
  logic       y0, y1;
  logic [7:0] exp0, exp1;
  logic [7:0] tab0, tab1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [3:0] mc0, mc1;
  int         mode;

  int n_chk;
  int n_fail;

  logic [2:0] h_din  [0:63];
  logic       h_done [0:63];
  logic       h_busy [0:63];
  logic       h_pass [0:63];
  logic [2:0] seq    [0:7];

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_in(din0), .dut_out(y0),
    .expected(exp0), .table_out(tab0), .busy(busy0), .done(done0),
    .pass(pass0), .mismatch_cnt(mc0)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_in(din1), .dut_out(y1),
    .expected(exp1), .table_out(tab1), .busy(busy1), .done(done1),
    .pass(pass1), .mismatch_cnt(mc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Student DUTs: mode 0 is y=a^b^c, mode 1 is y=a&b; second instance is y=~c.
  always_comb y0 = (mode == 0) ? (din0[2] ^ din0[1] ^ din0[0]) : (din0[2] & din0[1]);
  assign y1 = ~din1[0];

  // Start is driven after edge 0 and sampled at edge 1; history index c is "after edge c".
  task automatic drive_sweep(input int ncyc, input int restart_at, input bit hold);
    @(posedge clk); #1;
    start0 = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      h_din[c]  = din0;
      h_done[c] = done0;
      h_busy[c] = busy0;
      h_pass[c] = pass0;
      start0    = hold || (c == restart_at);
    end
    start0 = 1'b0;
  endtask

  function automatic int first_done(input int ncyc);
    for (int c = 1; c <= ncyc; c++) if (h_done[c] === 1'b1) return c;
    return -1;
  endfunction

  function automatic int count_done(input int ncyc);
    int n = 0;
    for (int c = 1; c <= ncyc; c++) if (h_done[c] === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (din0 !== 3'd0) begin n_fail++; $display("FAIL reset_dut_in got %0d exp 0", din0); end
    n_chk++; if (tab0 !== 8'h00) begin n_fail++; $display("FAIL reset_table got %h exp 00", tab0); end
    n_chk++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy0); end
    n_chk++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done0); end
    n_chk++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b exp 0", pass0); end
    n_chk++; if (mc0 !== 4'd0) begin n_fail++; $display("FAIL reset_mcnt got %0d exp 0", mc0); end
    rst = 1'b0;
  endtask

  task automatic test_xor_pass();
    int d;
    mode = 0; exp0 = 8'h96;
    drive_sweep(30, -1, 1'b0);
    d = first_done(30);
    n_chk++; if (d != 25) begin n_fail++; $display("FAIL xor_done_cycle got %0d exp 25", d); end
    n_chk++; if (count_done(30) != 1) begin n_fail++; $display("FAIL xor_done_count got %0d exp 1", count_done(30)); end
    n_chk++; if (h_busy[24] !== 1'b1) begin n_fail++; $display("FAIL xor_busy_last_drive got %b exp 1", h_busy[24]); end
    n_chk++; if (h_busy[25] !== 1'b0) begin n_fail++; $display("FAIL xor_busy_in_done got %b exp 0", h_busy[25]); end
    n_chk++; if (h_pass[25] !== 1'b1) begin n_fail++; $display("FAIL xor_pass_at_done got %b exp 1", h_pass[25]); end
    n_chk++; if (tab0 !== 8'h96) begin n_fail++; $display("FAIL xor_table got %h exp 96", tab0); end
    n_chk++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL xor_pass_held got %b exp 1", pass0); end
    n_chk++; if (mc0 !== 4'd0) begin n_fail++; $display("FAIL xor_mcnt got %0d exp 0", mc0); end
  endtask

  task automatic test_xor_mismatch();
    int d;
    mode = 0; exp0 = 8'h97;
    drive_sweep(30, -1, 1'b0);
    d = first_done(30);
    n_chk++; if (d != 25) begin n_fail++; $display("FAIL mis_done_cycle got %0d exp 25", d); end
    n_chk++; if (tab0 !== 8'h96) begin n_fail++; $display("FAIL mis_table got %h exp 96", tab0); end
    n_chk++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL mis_pass got %b exp 0", pass0); end
    n_chk++; if (mc0 !== 4'd1) begin n_fail++; $display("FAIL mis_mcnt got %0d exp 1", mc0); end
  endtask

  task automatic test_vec_order();
    mode = 1; exp0 = 8'hC0;
    drive_sweep(30, -1, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      n_chk++;
      if (h_din[c] !== seq[(c-1)/3]) begin
        n_fail++; $display("FAIL order_dut_in cycle %0d got %0d exp %0d", c, h_din[c], seq[(c-1)/3]);
      end
    end
    for (int c = 25; c <= 30; c++) begin
      n_chk++;
      if (h_din[c] !== seq[7]) begin
        n_fail++; $display("FAIL order_dut_in_hold cycle %0d got %0d exp %0d", c, h_din[c], seq[7]);
      end
    end
    n_chk++; if (tab0 !== 8'hC0) begin n_fail++; $display("FAIL and_table got %h exp c0", tab0); end
    n_chk++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL and_pass got %b exp 1", pass0); end
    n_chk++; if (mc0 !== 4'd0) begin n_fail++; $display("FAIL and_mcnt got %0d exp 0", mc0); end
  endtask

  task automatic test_settle0();
    int d = -1;
    int nd = 0;
    exp1 = 8'h55;
    @(posedge clk); #1;
    start1 = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if (done1 === 1'b1) begin nd++; if (d < 0) d = c; end
    end
    n_chk++; if (d != 9) begin n_fail++; $display("FAIL s0_done_cycle got %0d exp 9", d); end
    n_chk++; if (nd != 1) begin n_fail++; $display("FAIL s0_done_count got %0d exp 1", nd); end
    n_chk++; if (tab1 !== 8'h55) begin n_fail++; $display("FAIL s0_table got %h exp 55", tab1); end
    n_chk++; if (pass1 !== 1'b1) begin n_fail++; $display("FAIL s0_pass got %b exp 1", pass1); end
    n_chk++; if (mc1 !== 4'd0) begin n_fail++; $display("FAIL s0_mcnt got %0d exp 0", mc1); end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    int d;
    mode = 0; exp0 = 8'h96;
    @(posedge clk); #1;
    start0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start0 = 1'b0;
    end
    n_chk++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b exp 1", busy0); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++; if (din0 !== 3'd0) begin n_fail++; $display("FAIL rmid_dut_in got %0d exp 0", din0); end
    n_chk++; if (tab0 !== 8'h00) begin n_fail++; $display("FAIL rmid_table got %h exp 00", tab0); end
    n_chk++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", busy0); end
    n_chk++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rmid_done got %b exp 0", done0); end
    n_chk++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL rmid_pass got %b exp 0", pass0); end
    n_chk++; if (mc0 !== 4'd0) begin n_fail++; $display("FAIL rmid_mcnt got %0d exp 0", mc0); end
    for (int c = 12; c <= 45; c++) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) nd++;
    end
    n_chk++; if (nd != 0) begin n_fail++; $display("FAIL rmid_no_done got %0d exp 0", nd); end
    drive_sweep(30, -1, 1'b0);
    d = first_done(30);
    n_chk++; if (d != 25) begin n_fail++; $display("FAIL rmid_restart_done got %0d exp 25", d); end
    n_chk++; if (tab0 !== 8'h96) begin n_fail++; $display("FAIL rmid_restart_table got %h exp 96", tab0); end
    n_chk++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL rmid_restart_pass got %b exp 1", pass0); end
  endtask

  task automatic test_ignored_start();
    int d;
    mode = 0; exp0 = 8'h96;
    drive_sweep(40, 5, 1'b0);
    d = first_done(40);
    n_chk++; if (count_done(40) != 1) begin n_fail++; $display("FAIL ign_done_count got %0d exp 1", count_done(40)); end
    n_chk++; if (d != 25) begin n_fail++; $display("FAIL ign_done_cycle got %0d exp 25", d); end
    n_chk++; if (tab0 !== 8'h96) begin n_fail++; $display("FAIL ign_table got %h exp 96", tab0); end
  endtask

  task automatic test_back_to_back();
    mode = 0; exp0 = 8'h96;
    drive_sweep(55, -1, 1'b1);
    n_chk++; if (count_done(55) != 2) begin n_fail++; $display("FAIL b2b_done_count got %0d exp 2", count_done(55)); end
    n_chk++; if (h_done[25] !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got %b exp 1", h_done[25]); end
    n_chk++; if (h_done[51] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got %b exp 1", h_done[51]); end
    n_chk++; if (h_pass[26] !== 1'b1) begin n_fail++; $display("FAIL b2b_pass_idle got %b exp 1", h_pass[26]); end
    n_chk++; if (h_pass[27] !== 1'b0) begin n_fail++; $display("FAIL b2b_pass_cleared got %b exp 0", h_pass[27]); end
    n_chk++; if (h_busy[28] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_restart got %b exp 1", h_busy[28]); end
    n_chk++; if (h_pass[51] !== 1'b1) begin n_fail++; $display("FAIL b2b_pass_second got %b exp 1", h_pass[51]); end
    repeat (30) @(posedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    mode = 0; exp0 = 8'h00; exp1 = 8'h00;
`ifdef SWEEP_GRAY_EN
    seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd3; seq[3] = 3'd2;
    seq[4] = 3'd6; seq[5] = 3'd7; seq[6] = 3'd5; seq[7] = 3'd4;
`else
    seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd3;
    seq[4] = 3'd4; seq[5] = 3'd5; seq[6] = 3'd6; seq[7] = 3'd7;
`endif
    test_reset();
    test_xor_pass();
    test_xor_mismatch();
    test_vec_order();
    test_settle0();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
